iom_bus_arbiter: RTL

// Two-requester round-robin arbiter and bus-cycle sequencer for the shared 8-bit IOM bus.

---
 rtl/iom_bus_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/iom_bus_arbiter.sv
// iom_bus_arbiter: two-requester round-robin arbiter and 4-phase IOM bus-cycle sequencer.
// Bus outputs decode from the registered phase and the request fields captured at grant.
module iom_bus_arbiter #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8,
    parameter int RECOV  = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [1:0]             REQ,
    input  logic [1:0]             REQ_WE,
    input  logic [1:0]             REQ_IOM,
    input  logic [1:0][ADDR_W-1:0] REQ_ADDR,
    input  logic [1:0][DATA_W-1:0] REQ_WDATA,
    output logic [1:0]             GNT,
    output logic [1:0]             DONE,
    output logic [DATA_W-1:0]      RDATA,
    output logic                   ALE,
    output logic                   RD,
    output logic                   WR,
    output logic                   CS_MEM,
    output logic                   CS_IO,
    output logic [ADDR_W-1:0]      Address,
    inout  wire  [DATA_W-1:0]      Data
);

    localparam int CW = (RECOV < 2) ? 1 : $clog2(RECOV);
    localparam logic [CW-1:0] RLAST = CW'(RECOV - 1);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       rcnt_q, rcnt_d;
    logic                win_q, win_d;
    logic                prio_q, prio_d;
    logic                cap;
    logic                we_q, iom_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // prio_q names the requester that wins a tie; it flips away from each winner.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        win_d   = win_q;
        prio_d  = prio_q;
        rdata_d = rdata_q;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: if (|REQ) begin
                cap     = 1'b1;
                win_d   = (REQ == 2'b11) ? prio_q : REQ[1];
                prio_d  = ~win_d;
                state_d = S_T1;
            end
            S_T1: state_d = S_T2;
            S_T2: state_d = S_T3;
            S_T3: begin
                state_d = S_T4;
                rcnt_d  = '0;
                if (!we_q) rdata_d = Data;
            end
            S_T4: begin
                if (rcnt_q == RLAST) state_d = S_IDLE;
                else                 rcnt_d  = rcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            win_q   <= 1'b0;
            prio_q  <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            iom_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            win_q   <= win_d;
            prio_q  <= prio_d;
            rdata_q <= rdata_d;
            if (cap) begin
                we_q    <= REQ_WE[win_d];
                iom_q   <= REQ_IOM[win_d];
                addr_q  <= REQ_ADDR[win_d];
                wdata_q <= REQ_WDATA[win_d];
            end
        end
    end

    logic busy, sel, strobe, last;
    assign busy   = (state_q != S_IDLE);
    assign sel    = (state_q == S_T1) || (state_q == S_T2) || (state_q == S_T3);
    assign strobe = (state_q == S_T2) || (state_q == S_T3);
    assign last   = (state_q == S_T4) && (rcnt_q == RLAST);

    assign GNT     = {busy & win_q, busy & ~win_q};
    assign DONE    = {last & win_q, last & ~win_q};
    assign RDATA   = rdata_q;
    assign ALE     = (state_q == S_T1);
    assign RD      = ~(strobe & ~we_q);
    assign WR      = ~(strobe & we_q);
    assign CS_MEM  = sel & ~iom_q;
    assign CS_IO   = sel & iom_q;
    assign Address = busy ? addr_q : '0;
    assign Data    = (strobe & we_q) ? wdata_q : 'z;

endmodule
